// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling blocks: default pixel width,
// controller state encoding and counter width helper.
package cnn_pkg;

  localparam int BIT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational two's-complement signed maximum of two pixels.
module pool_max2
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic signed [BIT_WIDTH-1:0] a_i,
  input  logic signed [BIT_WIDTH-1:0] b_i,
  output logic signed [BIT_WIDTH-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 max-pooling controller: takes one column of a row pair per accept and
// emits one pooled pixel for every two columns, row-major through the frame.
module maxpool_ctrl
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH     = BIT_WIDTH_DEF,
  parameter int IMG_WIDTH     = 28,
  parameter int NUM_ROW_PAIRS = 14,
  localparam int COL_W        = cnt_w(IMG_WIDTH),
  localparam int ROW_W        = cnt_w(NUM_ROW_PAIRS),
  localparam int OCOL_W       = cnt_w(IMG_WIDTH / 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in1,
  input  logic signed [BIT_WIDTH-1:0] in2,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic [OCOL_W-1:0]           out_col,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output pool_state_e                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its payload stable until then.

  pool_state_e                 state_q, state_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic signed [BIT_WIDTH-1:0] hold_q, hold_d;
  logic signed [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic [OCOL_W-1:0]           out_col_q, out_col_d;
  logic                        out_valid_q, out_valid_d;

  logic signed [BIT_WIDTH-1:0] pair_max, hold_in1_max, win_max;
  logic                        accept;

  pool_max2 #(.BIT_WIDTH(BIT_WIDTH)) u_pair (.a_i(in1),          .b_i(in2), .max_o(pair_max));
  pool_max2 #(.BIT_WIDTH(BIT_WIDTH)) u_hold (.a_i(hold_q),       .b_i(in1), .max_o(hold_in1_max));
  pool_max2 #(.BIT_WIDTH(BIT_WIDTH)) u_win  (.a_i(hold_in1_max), .b_i(in2), .max_o(win_max));

  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_valid_d = out_valid_q;

    // A handshake frees the output slot; an odd-column load below may refill it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          hold_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (!col_q[0]) begin
            hold_d = pair_max;
          end else begin
            out_data_d  = win_max;
            out_col_d   = OCOL_W'(col_q >> 1);
            out_valid_d = 1'b1;
          end
          if (col_q == COL_W'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(NUM_ROW_PAIRS - 1)) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl with a 4-pixel-wide, 2-row-pair frame of 8-bit pixels.
module tb_maxpool_ctrl;
  import cnn_pkg::*;

  localparam int BW   = 8;
  localparam int IW   = 4;
  localparam int NRP  = 2;
  localparam int OCW  = 1;
  localparam int W    = BW + OCW;
  localparam int NCOL = IW * NRP;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic signed [BW-1:0] in1, in2;
  logic in_ready, out_valid, busy, done;
  logic signed [BW-1:0] out_data;
  logic [OCW-1:0] out_col;
  pool_state_e dbg_state;

  always #5 clk = ~clk;

  maxpool_ctrl #(.BIT_WIDTH(BW), .IMG_WIDTH(IW), .NUM_ROW_PAIRS(NRP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_col(out_col), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: set by the test
  bit in_frame = 1'b0;
  int done_cnt = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int col, input int val);
    exp_q.push_back({OCW'(col), BW'(val)});
  endtask

  // Samples 2 time units after the falling edge, after the driver has set
  // this cycle's inputs, so it sees what the next rising edge will see.
  logic prev_stall = 1'b0;
  logic signed [BW-1:0] prev_data;
  logic [OCW-1:0] prev_col;
  logic [W-1:0] mon_w;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_col", out_col, prev_col);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (!busy) check("idle_in_ready", in_ready, 0);
      if (in_frame) check("busy_in_frame", busy, 1);
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          mon_w = exp_q.pop_front();
          check("out_data", out_data, $signed(mon_w[BW-1:0]));
          check("out_col", out_col, mon_w[W-1:BW]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_col   = out_col;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready();
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    set_ready();
  endtask

  task automatic drive_col(input int a, input int b, input bit odd);
    bit acc = 1'b0;
    in1 = BW'(a);
    in2 = BW'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      #1;
      acc = in_ready;
      @(negedge clk);
      #1;
      set_ready();
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    else if (odd) check("odd_latency", out_valid, 1);
  endtask

  task automatic start_frame();
    check("pre_start_idle", dbg_state, ST_IDLE);
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_frame = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (dbg_state != ST_IDLE && n < 200) begin
      tick();
      n++;
    end
    in_frame = 1'b0;
    check("done_timeout", (n < 200), 1);
    check("done_pulses", done_cnt, 1);
    check("exp_q_empty", exp_q.size(), 0);
    check("end_in_ready", in_ready, 0);
    check("end_busy", busy, 0);
  endtask

  // ---------------- table of 2x2 windows ----------------
  typedef struct {
    int a;   // in1, even column
    int b;   // in2, even column
    int c;   // in1, odd column
    int d;   // in2, odd column
    int exp_max;
  } win_vec_t;

  win_vec_t tbl[8];

  task automatic run_table_frame(input int base, input bit glitch);
    start_frame();
    for (int k = 0; k < 4; k++) push_exp(k % 2, tbl[base + k].exp_max);
    for (int k = 0; k < 4; k++) begin
      drive_col(tbl[base + k].a, tbl[base + k].b, 1'b0);
      drive_col(tbl[base + k].c, tbl[base + k].d, 1'b1);
      if (glitch && k == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    wait_done();
  endtask

  // ---------------- reference model for random frames ----------------
  int rc1[NCOL];
  int rc2[NCOL];

  function automatic int rand_pix();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic model_frame();
    for (int rp = 0; rp < NRP; rp++) begin
      for (int w = 0; w < IW / 2; w++) begin
        int base = rp * IW + 2 * w;
        int vals[4] = '{rc1[base], rc2[base], rc1[base + 1], rc2[base + 1]};
        int m = -1000;
        foreach (vals[j]) if (vals[j] > m) m = vals[j];
        push_exp(w, m);
      end
    end
  endtask

  task automatic run_random_frame();
    for (int i = 0; i < NCOL; i++) begin
      rc1[i] = rand_pix();
      rc2[i] = rand_pix();
    end
    start_frame();
    model_frame();
    for (int i = 0; i < NCOL; i++) begin
      drive_col(rc1[i], rc2[i], i[0]);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_done();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{a: 1,    b: 5,    c: 3,    d: 2,    exp_max: 5};
    tbl[1] = '{a: -4,   b: -7,   c: -2,   d: -9,   exp_max: -2};
    tbl[2] = '{a: -128, b: 127,  c: -128, d: -128, exp_max: 127};
    tbl[3] = '{a: -128, b: -128, c: -128, d: -128, exp_max: -128};
    tbl[4] = '{a: 0,    b: -1,   c: -1,   d: 0,    exp_max: 0};
    tbl[5] = '{a: 7,    b: 7,    c: 7,    d: 7,    exp_max: 7};
    tbl[6] = '{a: -3,   b: -5,   c: -100, d: -4,   exp_max: -3};
    tbl[7] = '{a: 100,  b: -100, c: 99,   d: 101,  exp_max: 101};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    ready_mode = 0;
    tick();

    // Basic frames, then a start pulse in the middle of a frame.
    run_table_frame(0, 1'b0);
    run_table_frame(4, 1'b1);

    // Output held back for five cycles by the consumer.
    ready_mode = 2;
    out_ready = 1'b0;
    start_frame();
    for (int k = 0; k < 4; k++) push_exp(k % 2, tbl[k].exp_max);
    drive_col(tbl[0].a, tbl[0].b, 1'b0);
    drive_col(tbl[0].c, tbl[0].d, 1'b1);
    in1 = BW'(tbl[1].a);
    in2 = BW'(tbl[1].b);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_out_data", out_data, 5);
      check("hold_out_col", out_col, 0);
      @(negedge clk);
      #1;
    end
    ready_mode = 0;
    out_ready = 1'b1;
    drive_col(tbl[1].a, tbl[1].b, 1'b0);
    drive_col(tbl[1].c, tbl[1].d, 1'b1);
    for (int k = 2; k < 4; k++) begin
      drive_col(tbl[k].a, tbl[k].b, 1'b0);
      drive_col(tbl[k].c, tbl[k].d, 1'b1);
    end
    wait_done();

    // Reset in the middle of a frame, then a clean frame.
    start_frame();
    push_exp(0, tbl[0].exp_max);
    drive_col(tbl[0].a, tbl[0].b, 1'b0);
    drive_col(tbl[0].c, tbl[0].d, 1'b1);
    drive_col(tbl[1].a, tbl[1].b, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_col", out_col, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_exp_drained", exp_q.size(), 0);
    exp_q.delete();
    in_frame = 1'b0;
    tick();
    rst = 1'b0;
    in1 = 8'sd55;
    in2 = 8'sd66;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("post_rst_no_output", out_valid, 0);
    check("post_rst_idle", dbg_state, ST_IDLE);
    run_table_frame(4, 1'b0);

    // Random pixels, random consumer back-pressure.
    ready_mode = 1;
    for (int f = 0; f < 12; f++) run_random_frame();

    ready_mode = 0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t expected end before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
